// File: rtl/gmem_read_arbiter.sv
// gmem_read_arbiter: round-robin sharing of one AXI4 read path between two burst requesters.
// One burst in flight at a time; the grant is held from AR issue until the RLAST handshake.
module gmem_read_arbiter #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] req0_araddr,
  input  logic [7:0]            req0_arlen,
  input  logic                  req0_arvalid,
  output logic                  req0_arready,
  output logic [DATA_WIDTH-1:0] req0_rdata,
  output logic [1:0]            req0_rresp,
  output logic                  req0_rlast,
  output logic                  req0_rvalid,
  input  logic                  req0_rready,
  input  logic [ADDR_WIDTH-1:0] req1_araddr,
  input  logic [7:0]            req1_arlen,
  input  logic                  req1_arvalid,
  output logic                  req1_arready,
  output logic [DATA_WIDTH-1:0] req1_rdata,
  output logic [1:0]            req1_rresp,
  output logic                  req1_rlast,
  output logic                  req1_rvalid,
  input  logic                  req1_rready,
  output logic [ADDR_WIDTH-1:0] m_axi_gmem_araddr,
  output logic [7:0]            m_axi_gmem_arlen,
  output logic                  m_axi_gmem_arvalid,
  output logic [ID_WIDTH-1:0]   m_axi_gmem_arid,
  output logic [2:0]            m_axi_gmem_arsize,
  output logic [1:0]            m_axi_gmem_arburst,
  input  logic                  m_axi_gmem_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_gmem_rdata,
  input  logic [1:0]            m_axi_gmem_rresp,
  input  logic                  m_axi_gmem_rlast,
  input  logic                  m_axi_gmem_rvalid,
  output logic                  m_axi_gmem_rready,
  output logic                  proto_err,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t     state_q, state_d;
  logic       grant_q, grant_d, ptr_q, ptr_d, err_q, err_d;
  logic [7:0] cnt_q, cnt_d;
  logic       in_addr, d0, d1, r_hs;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      ptr_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (req0_arvalid | req1_arvalid) begin
        grant_d = (req0_arvalid & req1_arvalid) ? ptr_q : req1_arvalid;
        state_d = ADDR;
      end
      ADDR: if (m_axi_gmem_arready) begin
        cnt_d   = m_axi_gmem_arlen;
        state_d = DATA;
      end
      DATA: if (r_hs) begin
        cnt_d = (cnt_q != '0) ? cnt_q - 8'd1 : cnt_q;
        // RLAST must coincide with the counter reaching zero; anything else is sticky-flagged
        if (m_axi_gmem_rlast) begin
          state_d = IDLE;
          ptr_d   = ~grant_q;
          err_d   = err_q | (cnt_q != '0);
        end else begin
          err_d = err_q | (cnt_q == '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    in_addr            = state_q == ADDR;
    d0                 = (state_q == DATA) & ~grant_q;
    d1                 = (state_q == DATA) & grant_q;
    busy               = state_q != IDLE;
    proto_err          = err_q;
    m_axi_gmem_arvalid = in_addr;
    m_axi_gmem_araddr  = !in_addr ? '0 : grant_q ? req1_araddr : req0_araddr;
    m_axi_gmem_arlen   = !in_addr ? '0 : grant_q ? req1_arlen : req0_arlen;
    m_axi_gmem_arid    = in_addr ? ID_WIDTH'(grant_q) : '0;
    m_axi_gmem_arsize  = 3'($clog2(DATA_WIDTH / 8));
    m_axi_gmem_arburst = 2'b01;
    req0_arready       = in_addr & ~grant_q & m_axi_gmem_arready;
    req1_arready       = in_addr & grant_q & m_axi_gmem_arready;
    m_axi_gmem_rready  = (d0 & req0_rready) | (d1 & req1_rready);
    r_hs               = m_axi_gmem_rvalid & m_axi_gmem_rready;
    req0_rvalid        = d0 & m_axi_gmem_rvalid;
    req0_rlast         = d0 & m_axi_gmem_rlast;
    req0_rresp         = d0 ? m_axi_gmem_rresp : 2'b00;
    req0_rdata         = d0 ? m_axi_gmem_rdata : '0;
    req1_rvalid        = d1 & m_axi_gmem_rvalid;
    req1_rlast         = d1 & m_axi_gmem_rlast;
    req1_rresp         = d1 ? m_axi_gmem_rresp : 2'b00;
    req1_rdata         = d1 ? m_axi_gmem_rdata : '0;
  end
endmodule

// File: tb/tb_gmem_read_arbiter.sv
// tb_gmem_read_arbiter: arbitration table, directed corner sequences and randomized bursts
// checked against a transaction-level round-robin / beat-count model.
module tb_gmem_read_arbiter;
  logic        clk = 1'b0, reset;
  logic [63:0] req0_araddr, req1_araddr, m_axi_gmem_araddr;
  logic [7:0]  req0_arlen, req1_arlen, m_axi_gmem_arlen;
  logic        req0_arvalid, req1_arvalid, req0_arready, req1_arready;
  logic [31:0] req0_rdata, req1_rdata, m_axi_gmem_rdata;
  logic [1:0]  req0_rresp, req1_rresp, m_axi_gmem_rresp, m_axi_gmem_arburst;
  logic        req0_rlast, req1_rlast, req0_rvalid, req1_rvalid, req0_rready, req1_rready;
  logic [0:0]  m_axi_gmem_arid;
  logic [2:0]  m_axi_gmem_arsize;
  logic        m_axi_gmem_arvalid, m_axi_gmem_arready, m_axi_gmem_rlast, m_axi_gmem_rvalid;
  logic        m_axi_gmem_rready, proto_err, busy;
  int n_cmp = 0, n_err = 0;
  int fav;
  bit err_m;
  typedef struct {int prev; bit v0; bit v1; bit exp_id;} arb_vec_t;
  arb_vec_t vecs[8];

  gmem_read_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_araddr(req0_araddr), .req0_arlen(req0_arlen), .req0_arvalid(req0_arvalid),
    .req0_arready(req0_arready), .req0_rdata(req0_rdata), .req0_rresp(req0_rresp),
    .req0_rlast(req0_rlast), .req0_rvalid(req0_rvalid), .req0_rready(req0_rready),
    .req1_araddr(req1_araddr), .req1_arlen(req1_arlen), .req1_arvalid(req1_arvalid),
    .req1_arready(req1_arready), .req1_rdata(req1_rdata), .req1_rresp(req1_rresp),
    .req1_rlast(req1_rlast), .req1_rvalid(req1_rvalid), .req1_rready(req1_rready),
    .m_axi_gmem_araddr(m_axi_gmem_araddr), .m_axi_gmem_arlen(m_axi_gmem_arlen),
    .m_axi_gmem_arvalid(m_axi_gmem_arvalid), .m_axi_gmem_arid(m_axi_gmem_arid),
    .m_axi_gmem_arsize(m_axi_gmem_arsize), .m_axi_gmem_arburst(m_axi_gmem_arburst),
    .m_axi_gmem_arready(m_axi_gmem_arready), .m_axi_gmem_rdata(m_axi_gmem_rdata),
    .m_axi_gmem_rresp(m_axi_gmem_rresp), .m_axi_gmem_rlast(m_axi_gmem_rlast),
    .m_axi_gmem_rvalid(m_axi_gmem_rvalid), .m_axi_gmem_rready(m_axi_gmem_rready),
    .proto_err(proto_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic bit winner(input bit v0, input bit v1);
    return (v0 && v1) ? bit'(fav) : v1;
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    {req0_arvalid, req1_arvalid, req0_rready, req1_rready} = 4'b0;
    {m_axi_gmem_arready, m_axi_gmem_rvalid, m_axi_gmem_rlast} = 3'b0;
    req0_araddr = '0; req1_araddr = '0; req0_arlen = '0; req1_arlen = '0;
    m_axi_gmem_rdata = '0; m_axi_gmem_rresp = '0;
    fav = 0; err_m = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_state", {busy, proto_err, m_axi_gmem_arvalid, m_axi_gmem_rready, req0_rvalid,
                        req1_rvalid, req0_arready, req1_arready}, 0);
  endtask

  task automatic req(input bit id, input logic [63:0] a, input logic [7:0] l);
    if (id) begin req1_arvalid = 1'b1; req1_araddr = a; req1_arlen = l; end
    else begin req0_arvalid = 1'b1; req0_araddr = a; req0_arlen = l; end
  endtask

  // Acts as AXI slave for one burst expected to be granted to requester id; rlast is sent on beat last_at.
  task automatic serve(input bit id, input logic [63:0] addr, input logic [7:0] len, input int last_at,
                       input int ar_delay, input bit toggle, input bit gaps, input int abort_at);
    int b = 0;
    bit r, v, hs, done = 1'b0;
    logic [31:0] d;
    #1;
    check("idle_quiet", {busy, m_axi_gmem_arvalid, req0_arready, req1_arready}, 0);
    @(negedge clk); #1;
    check("arvalid", m_axi_gmem_arvalid, 1);
    check("arid", m_axi_gmem_arid, id);
    check("araddr", m_axi_gmem_araddr, addr);
    check("arlen", m_axi_gmem_arlen, len);
    for (int i = 0; i < ar_delay; i++) begin
      check("ar_hold", {m_axi_gmem_arvalid, req1_arready, req0_arready}, 3'b100);
      @(negedge clk); #1;
    end
    m_axi_gmem_arready = 1'b1; #1;
    check("arready_route", {req1_arready, req0_arready}, id ? 2'b10 : 2'b01);
    @(negedge clk);
    m_axi_gmem_arready = 1'b0;
    if (id) req1_arvalid = 1'b0; else req0_arvalid = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      d = $urandom;
      r = toggle ? (c % 2 == 0) : 1'b1;
      v = (gaps && b != abort_at) ? ($urandom_range(0, 3) != 0) : 1'b1;
      m_axi_gmem_rvalid = v;
      m_axi_gmem_rdata = d;
      m_axi_gmem_rresp = 2'(b);
      m_axi_gmem_rlast = (b == last_at);
      if (id) begin req1_rready = r; req0_rready = 1'($urandom_range(0, 1)); end
      else begin req0_rready = r; req1_rready = 1'($urandom_range(0, 1)); end
      #1;
      if (b == abort_at) begin
        reset = 1'b0; #1;
        check("abort_zero", {busy, m_axi_gmem_arvalid, m_axi_gmem_rready, req0_arready, req1_arready,
                             req0_rvalid, req1_rvalid, req0_rlast, req1_rlast, req0_rresp, req1_rresp}, 0);
        check("abort_data", {m_axi_gmem_araddr, req0_rdata | req1_rdata}, 0);
        return;
      end
      check("m_rready", m_axi_gmem_rready, r);
      check("rvalid_route", {req1_rvalid, req0_rvalid}, !v ? 2'b00 : id ? 2'b10 : 2'b01);
      check("rdata_other", id ? req0_rdata : req1_rdata, 0);
      if (v)
        check("beat", {id ? req1_rlast : req0_rlast, id ? req1_rresp : req0_rresp,
                       id ? req1_rdata : req0_rdata}, {b == last_at, 2'(b), d});
      hs = v && r;
      done = hs && (b == last_at);
      if (hs) b++;
      @(negedge clk);
    end
    m_axi_gmem_rvalid = 1'b0; m_axi_gmem_rlast = 1'b0; req0_rready = 1'b0; req1_rready = 1'b0;
    #1;
    check("burst_done", done, 1);
    check("busy_fall", busy, 0);
    fav = id ? 0 : 1;
    err_m = err_m | (last_at != int'(len));
    check("proto_err", proto_err, err_m);
  endtask

  initial begin
    bit pend[2];
    logic [63:0] pa[2];
    logic [7:0] pl[2];
    bit w;
    int la, p;
    vecs = '{'{0, 1, 0, 0}, '{0, 0, 1, 1}, '{0, 1, 1, 0}, '{1, 1, 1, 1},
             '{2, 1, 1, 0}, '{1, 1, 0, 0}, '{2, 0, 1, 1}, '{1, 0, 1, 1}};
    do_reset();
    check("arsize", m_axi_gmem_arsize, 2);
    check("arburst", m_axi_gmem_arburst, 1);
    // prev: 0 = fresh from reset, 1/2 = requester 0/1 just completed a burst
    foreach (vecs[k]) begin
      do_reset();
      if (vecs[k].prev != 0) begin
        req(bit'(vecs[k].prev - 1), 64'h100, 8'd0);
        serve(bit'(vecs[k].prev - 1), 64'h100, 8'd0, 0, 0, 1'b0, 1'b0, -1);
      end
      if (vecs[k].v0) req(1'b0, 64'hA0, 8'd1);
      if (vecs[k].v1) req(1'b1, 64'hB0, 8'd2);
      serve(vecs[k].exp_id, vecs[k].exp_id ? 64'hB0 : 64'hA0, vecs[k].exp_id ? 8'd2 : 8'd1,
            vecs[k].exp_id ? 2 : 1, 0, 1'b0, 1'b0, -1);
    end
    do_reset();
    req(1'b0, 64'h1000, 8'd3);
    serve(1'b0, 64'h1000, 8'd3, 3, 0, 1'b0, 1'b0, -1);
    do_reset();
    req(1'b0, 64'h1000, 8'd1);
    req(1'b1, 64'h2000, 8'd2);
    serve(1'b0, 64'h1000, 8'd1, 1, 0, 1'b0, 1'b0, -1);
    req(1'b0, 64'h3000, 8'd0);
    serve(1'b1, 64'h2000, 8'd2, 2, 0, 1'b0, 1'b0, -1);
    req(1'b1, 64'h4000, 8'd0);
    serve(1'b0, 64'h3000, 8'd0, 0, 0, 1'b0, 1'b0, -1);
    do_reset();
    req(1'b1, 64'h2000, 8'd7);
    serve(1'b1, 64'h2000, 8'd7, 7, 3, 1'b1, 1'b0, -1);
    do_reset();
    req(1'b0, 64'h3000, 8'd3);
    serve(1'b0, 64'h3000, 8'd3, 2, 0, 1'b0, 1'b0, -1);
    req(1'b1, 64'h3100, 8'd1);
    serve(1'b1, 64'h3100, 8'd1, 1, 0, 1'b0, 1'b0, -1);
    do_reset();
    req(1'b0, 64'h50, 8'd1);
    serve(1'b0, 64'h50, 8'd1, 3, 0, 1'b0, 1'b0, -1);
    do_reset();
    req(1'b0, 64'h60, 8'd0);
    serve(1'b0, 64'h60, 8'd0, 0, 0, 1'b0, 1'b0, -1);
    req(1'b1, 64'h4000, 8'd7);
    serve(1'b1, 64'h4000, 8'd7, 7, 0, 1'b0, 1'b0, 2);
    do_reset();
    req(1'b0, 64'h10, 8'd0);
    req(1'b1, 64'h20, 8'd0);
    serve(1'b0, 64'h10, 8'd0, 0, 0, 1'b0, 1'b0, -1);
    serve(1'b1, 64'h20, 8'd0, 0, 0, 1'b0, 1'b0, -1);
    do_reset();
    pend = '{1'b0, 1'b0};
    for (int it = 0; it < 40; it++) begin
      p = $urandom_range(0, 3);
      for (int q = 0; q < 2; q++)
        if (!pend[q] && ((p >> q) & 1) == 1) begin
          pend[q] = 1'b1;
          pa[q] = {$urandom, $urandom};
          pl[q] = 8'($urandom_range(0, 5));
          req(bit'(q), pa[q], pl[q]);
        end
      if (!pend[0] && !pend[1]) begin
        pend[0] = 1'b1;
        pa[0] = {$urandom, $urandom};
        pl[0] = 8'($urandom_range(0, 5));
        req(1'b0, pa[0], pl[0]);
      end
      w = winner(pend[0], pend[1]);
      la = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 6)) : int'(pl[w]);
      serve(w, pa[w], pl[w], la, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'b1, -1);
      pend[w] = 1'b0;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/gmem_read_arbiter.md
Name: gmem_read_arbiter

Overview:
- Shares one AXI4 master read path (m_axi_gmem AR/R channels) between two kernel-side read requesters.
- Grants one burst at a time, round-robin. Forwards the granted address phase, routes R beats back until RLAST, then releases the grant.
- Sits between the action datapath read ports and the m_axi_gmem read signals of teak_action_top_gmem.

Parameters:
- ADDR_WIDTH, 64, AXI address width
- DATA_WIDTH, 32, AXI data width (32/64/128/256/512)
- ID_WIDTH, 1, AXI ID width; ARID is driven with grant index zero-extended

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- req0_araddr  in  ADDR_WIDTH  requester 0 burst address
- req0_arlen  in  8  requester 0 burst length minus one
- req0_arvalid  in  1  requester 0 address valid
- req0_arready  out  1  requester 0 address accepted
- req0_rdata  out  DATA_WIDTH  read data to requester 0
- req0_rresp  out  2  read response to requester 0
- req0_rlast  out  1  last beat to requester 0
- req0_rvalid  out  1  read beat valid to requester 0
- req0_rready  in  1  requester 0 accepts beat
- req1_* (araddr, arlen, arvalid, arready, rdata, rresp, rlast, rvalid, rready): same as req0_*, for requester 1
- m_axi_gmem_araddr, arlen, arvalid  out  ADDR_WIDTH, 8, 1  forwarded address phase
- m_axi_gmem_arid  out  ID_WIDTH  grant index
- m_axi_gmem_arsize  out  3  constant log2(DATA_WIDTH/8)
- m_axi_gmem_arburst  out  2  constant 2'b01 (INCR)
- m_axi_gmem_arready  in  1  slave accepts address
- m_axi_gmem_rdata, rresp, rlast, rvalid  in  DATA_WIDTH, 2, 1, 1  slave read beat
- m_axi_gmem_rready  out  1  routed from granted requester
- proto_err  out  1  sticky: RLAST/beat-count mismatch seen
- busy  out  1  high when state is not IDLE

Behaviour:
- Reset (reset=0, async assert, sync deassert):
  - State IDLE, grant=0, priority pointer=0 (requester 0 favoured), beat counter=0, proto_err=0.
  - All valid/ready outputs 0, data outputs 0.
- States: IDLE, ADDR, DATA.
- IDLE:
  - Arbitrate on reqN_arvalid. If both are valid, the requester the pointer favours wins.
  - Winner is registered into grant; next state is ADDR.
  - No outputs are asserted in IDLE. An arvalid in cycle 0 gives m_axi_gmem_arvalid in cycle 1.
- ADDR:
  - m_axi_gmem_arvalid=1. araddr/arlen are muxed combinationally from the granted requester, which must hold them stable per AXI.
  - req[grant]_arready = m_axi_gmem_arready. The other requester's arready is 0.
  - On AR handshake: counter <= arlen, go to DATA.
- DATA:
  - req[grant]_rvalid/rdata/rresp/rlast come from the m_axi_gmem R signals; m_axi_gmem_rready = req[grant]_rready.
  - The non-granted requester sees rvalid=0 and rdata=0.
  - On each beat handshake: if counter≠0, decrement.
  - A handshake with rlast=1: go to IDLE and set pointer = ~grant. If counter≠0 at that point, set proto_err.
  - A handshake with counter==0 and rlast=0: set proto_err, stay in DATA until rlast.
- One burst outstanding at most; a new AR is never issued before RLAST of the current burst.
- Minimum turnaround: RLAST handshake in cycle N, next arvalid at N+2 (IDLE at N+1).
- The non-granted requester may assert and hold arvalid during a burst; it wins the next IDLE arbitration.
- Simultaneous requests after a burst by requester 0: requester 1 wins. Single requester: wins regardless of pointer.
- Reset asserted mid-burst:
  - Immediate return to IDLE with all outputs 0.
  - Outstanding slave beats are not drained; the system resets the interconnect together with this block.
- arlen=0: single-beat burst; the counter stays 0 and rlast is expected on the first beat.

Test Plan:
- Single request: req0 arvalid, addr 0x1000, arlen=3, arready held 1 → m_arvalid in cycle 1 with ARID=0; 4 beats routed to req0 only; busy falls the cycle after RLAST; proto_err=0.
- Contention: both requesters valid in the same cycle after reset → req0 granted (ARID=0). After its RLAST, req1 granted (ARID=1) without req0 dropping valid. A third burst with both valid → req0.
- Backpressure: req1 burst arlen=7, with req1_rready toggling 1/0 and m_arready delayed 3 cycles → all 8 beats delivered in order; m_rready mirrors req1_rready exactly; no beat is lost.
- Protocol error: arlen=3 with rlast on beat 2 → proto_err=1 and remains high after return to IDLE; the next burst arbitrates normally.
- Reset mid-burst: assert reset during beat 2 of an arlen=7 burst → all outputs 0 asynchronously, state IDLE, pointer favours req0 after release.
- Single-beat: arlen=0 with rlast on the first beat → IDLE next cycle; proto_err=0.
